// File: rtl/scm_ctrl_master.sv
// Control-path initiator: turns host register requests into 134-bit scm control words
// and collects read responses. Define SCM_CTRL_TIMEOUT_EN to enable the read-response timeout.
module scm_ctrl_master #(
   parameter logic [15:0] MODULE_ID   = 16'h8007,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter logic [5:0]  WORD_HDR    = 6'b010000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   input  logic         req_write,
   input  logic [31:0]  req_addr,
   input  logic [63:0]  req_wdata,
   output logic         req_ready,
   output logic         rsp_valid,
   output logic [63:0]  rsp_rdata,
   output logic         rsp_err,
   output logic [133:0] out_ctrl_data,
   output logic         out_ctrl_data_wr,
   input  logic         in_ctrl_ready,
   input  logic [133:0] in_ctrl_data,
   input  logic         in_ctrl_data_wr,
   output logic         out_ctrl_ready,
   output logic [15:0]  drop_cnt
);

   localparam logic [3:0] CMD_WR  = 4'hA;
   localparam logic [3:0] CMD_RD  = 4'h9;
   localparam logic [3:0] CMD_RSP = 4'hB;

   typedef enum logic [1:0] {IDLE_S, SEND_S, WAIT_S, DONE_S} state_t;

   state_t        state, state_next;
   logic          cap_write;
   logic [31:0]   cap_addr;
   logic [63:0]   cap_wdata;
   logic          req_accept, rsp_accept, rsp_match, rsp_drop, timeout_hit;
   logic          wr_next, err_next;
   logic [63:0]   rdata_next;
   logic          unused_bits;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign out_ctrl_ready = 1'b1;
   assign rsp_valid      = (state == DONE_S);
   assign req_accept     = req_valid & req_ready;
   assign rsp_accept     = in_ctrl_data_wr & out_ctrl_ready;
   assign rsp_match      = rsp_accept &&
                           (in_ctrl_data[127:124] == CMD_RSP) &&
                           (in_ctrl_data[111:96] == MODULE_ID) &&
                           (in_ctrl_data[95:64] == cap_addr);
   // Only a match while waiting is consumed; every other accepted word is dropped.
   assign rsp_drop       = rsp_accept && !((state == WAIT_S) && rsp_match);

`ifdef SCM_CTRL_TIMEOUT_EN
   logic [15:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                wait_cnt <= 16'd0;
      else if (state != WAIT_S)  wait_cnt <= 16'd0;
      else                       wait_cnt <= wait_cnt + 16'd1;
   end

   assign timeout_hit = (state == WAIT_S) && (wait_cnt == 16'(TIMEOUT_CYC - 1));
   assign unused_bits = ^{in_ctrl_data[133:128], in_ctrl_data[123:112]};
`else
   assign timeout_hit = 1'b0;
   assign unused_bits = ^{in_ctrl_data[133:128], in_ctrl_data[123:112], 16'(TIMEOUT_CYC)};
`endif

   always_comb begin
      state_next = state;
      wr_next    = 1'b0;
      err_next   = 1'b0;
      rdata_next = rsp_rdata;
      case (state)
         IDLE_S: if (req_accept) state_next = SEND_S;
         SEND_S: begin
            // The word is registered: leave once its pulse is actually on the bus.
            if (out_ctrl_data_wr) begin
               state_next = cap_write ? DONE_S : WAIT_S;
               if (cap_write) rdata_next = 64'd0;
            end else if (in_ctrl_ready) begin
               wr_next = 1'b1;
            end
         end
         WAIT_S: begin
            if (rsp_match) begin
               state_next = DONE_S;
               rdata_next = in_ctrl_data[63:0];
            end else if (timeout_hit) begin
               state_next = DONE_S;
               err_next   = 1'b1;
               rdata_next = 64'd0;
            end
         end
         DONE_S:  state_next = IDLE_S;
         default: state_next = IDLE_S;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE_S;
         req_ready        <= 1'b1;
         rsp_err          <= 1'b0;
         rsp_rdata        <= 64'd0;
         out_ctrl_data_wr <= 1'b0;
         out_ctrl_data    <= '0;
         drop_cnt         <= 16'd0;
         cap_write        <= 1'b0;
         cap_addr         <= 32'd0;
         cap_wdata        <= 64'd0;
      end else begin
         state            <= state_next;
         rsp_err          <= err_next;
         rsp_rdata        <= rdata_next;
         out_ctrl_data_wr <= wr_next;
         if (req_accept)             req_ready <= 1'b0;
         else if (state == DONE_S)   req_ready <= 1'b1;
         if (req_accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
         end
         if (wr_next)
            out_ctrl_data <= {WORD_HDR, cap_write ? CMD_WR : CMD_RD, 12'h000, MODULE_ID,
                              cap_addr, cap_write ? cap_wdata : 64'd0};
         if (rsp_drop) drop_cnt <= sat_inc16(drop_cnt);
      end
   end

endmodule

// File: tb/tb_scm_ctrl_master.sv
// Directed, table-driven bench for scm_ctrl_master (TIMEOUT_CYC=16).
module tb_scm_ctrl_master;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_write;
   logic [31:0]  req_addr;
   logic [63:0]  req_wdata;
   logic         req_ready, rsp_valid, rsp_err;
   logic [63:0]  rsp_rdata;
   logic [133:0] out_ctrl_data;
   logic         out_ctrl_data_wr;
   logic         in_ctrl_ready;
   logic [133:0] in_ctrl_data;
   logic         in_ctrl_data_wr;
   logic         out_ctrl_ready;
   logic [15:0]  drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [63:0]  wdata;
      int           stall;
      logic         rsp_en;
      int           rsp_dly;
      logic         bad_first;
      logic [31:0]  bad_addr;
      logic [63:0]  rsp_data;
      logic [133:0] exp_word;
      int           exp_lat;
      logic [63:0]  exp_rdata;
      logic         exp_err;
      logic [15:0]  exp_drop;
   } vec_t;

   vec_t vecs[6];

   scm_ctrl_master #(.MODULE_ID(16'h8007), .TIMEOUT_CYC(16), .WORD_HDR(6'b010000)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .out_ctrl_data(out_ctrl_data), .out_ctrl_data_wr(out_ctrl_data_wr),
      .in_ctrl_ready(in_ctrl_ready), .in_ctrl_data(in_ctrl_data), .in_ctrl_data_wr(in_ctrl_data_wr),
      .out_ctrl_ready(out_ctrl_ready), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [133:0] rsp_word(input logic [31:0] a, input logic [63:0] d);
      return {6'b010000, 4'hB, 12'h000, 16'h8007, a, d};
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_out_ctrl_ready"}, out_ctrl_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_wr"}, out_ctrl_data_wr, 0);
      chk({tag, "_data"}, out_ctrl_data, 0);
      chk({tag, "_rdata"}, rsp_rdata, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
   endtask

   // Cycle 0 is the accept cycle; cycle c is the c-th cycle after the accepting edge.
   task automatic run_vec(input string tag, input vec_t v);
      int pulses, pcyc, vcyc;
      logic [133:0] word;
      logic [63:0]  rd;
      logic         er;
      pulses = 0; pcyc = -1; vcyc = -1; word = '0; rd = '0; er = 1'b0;
      chk({tag, "_ready_idle"}, req_ready, 1);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      in_ctrl_ready = (v.stall == 0);
      step();
      req_valid = 1'b0;
      chk({tag, "_ready_busy"}, req_ready, 0);
      for (int c = 1; c <= 200; c++) begin
         if (out_ctrl_data_wr) begin
            pulses++;
            pcyc = c;
            word = out_ctrl_data;
         end
         if (rsp_valid) begin
            vcyc = c; rd = rsp_rdata; er = rsp_err;
            break;
         end
         in_ctrl_ready   = (c > v.stall);
         in_ctrl_data_wr = 1'b0;
         if (!v.wr && v.rsp_en && pcyc > 0) begin
            if (c == pcyc + v.rsp_dly) begin
               in_ctrl_data_wr = 1'b1;
               in_ctrl_data    = rsp_word(v.addr, v.rsp_data);
            end else if (v.bad_first && c == pcyc + v.rsp_dly - 2) begin
               in_ctrl_data_wr = 1'b1;
               in_ctrl_data    = rsp_word(v.bad_addr, 64'hBAD);
            end
         end
         step();
      end
      in_ctrl_data_wr = 1'b0;
      in_ctrl_ready   = 1'b1;
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_wr_cycle"}, pcyc, v.stall + 2);
      chk({tag, "_word"}, word, v.exp_word);
      chk({tag, "_latency"}, vcyc, v.exp_lat);
      chk({tag, "_rdata"}, rd, v.exp_rdata);
      chk({tag, "_err"}, er, v.exp_err);
      chk({tag, "_drop"}, drop_cnt, v.exp_drop);
      step();
      chk({tag, "_rsp_valid_1cyc"}, rsp_valid, 0);
      chk({tag, "_ready_back"}, req_ready, 1);
   endtask

   initial begin
      vec_t tv;
      int   seen;
      //          wr    addr          wdata                   stall en  dly bad   bad_addr      rsp_data               exp_word                                                        lat rdata                  err  drop
      vecs[0] = '{1'b1, 32'h70000000, 64'h82,                 0,  1'b0, 0,  1'b0, 32'h0,        64'h0,                 {6'b010000, 128'hA000_8007_7000_0000_0000_0000_0000_0082}, 3,  64'h0,                 1'b0, 16'd0};
      vecs[1] = '{1'b1, 32'h70000008, 64'h300,                20, 1'b0, 0,  1'b0, 32'h0,        64'h0,                 {6'b010000, 128'hA000_8007_7000_0008_0000_0000_0000_0300}, 23, 64'h0,                 1'b0, 16'd0};
      vecs[2] = '{1'b0, 32'h70000002, 64'h0,                  0,  1'b1, 10, 1'b0, 32'h0,        64'h30,                {6'b010000, 128'h9000_8007_7000_0002_0000_0000_0000_0000}, 13, 64'h30,                1'b0, 16'd0};
      vecs[3] = '{1'b0, 32'h70000002, 64'h0,                  0,  1'b1, 10, 1'b1, 32'h70000001, 64'hDEADBEEF_00000055, {6'b010000, 128'h9000_8007_7000_0002_0000_0000_0000_0000}, 13, 64'hDEADBEEF_00000055, 1'b0, 16'd1};
      vecs[4] = '{1'b0, 32'h70000100, 64'h0,                  3,  1'b1, 1,  1'b0, 32'h0,        64'hFFFF0000_12345678, {6'b010000, 128'h9000_8007_7000_0100_0000_0000_0000_0000}, 7,  64'hFFFF0000_12345678, 1'b0, 16'd1};
      vecs[5] = '{1'b1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFF,  0,  1'b0, 0,  1'b0, 32'h0,        64'h0,                 {6'b010000, 128'hA000_8007_FFFF_FFFC_FFFF_FFFF_FFFF_FFFF}, 3,  64'h0,                 1'b0, 16'd1};

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      in_ctrl_ready = 1'b1; in_ctrl_data = '0; in_ctrl_data_wr = 1'b0;
      step(); step();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

`ifdef SCM_CTRL_TIMEOUT_EN
      // Timeout: pulse in cycle 2, WAIT_S from cycle 3, rsp_valid 16 cycles later.
      tv = '{1'b0, 32'h70000010, 64'h0, 0, 1'b0, 0, 1'b0, 32'h0, 64'h0,
             {6'b010000, 128'h9000_8007_7000_0010_0000_0000_0000_0000}, 19, 64'h0, 1'b1, 16'd1};
      run_vec("timeout", tv);
      in_ctrl_data = rsp_word(32'h70000010, 64'h99); in_ctrl_data_wr = 1'b1;
      step();
      in_ctrl_data_wr = 1'b0;
      step();
      chk("late_rsp_drop", drop_cnt, 2);
`endif

      // Read with no response, then reset while it is still waiting.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70000020; in_ctrl_ready = 1'b1;
      step();
      req_valid = 1'b0;
      seen = 0;
`ifdef SCM_CTRL_TIMEOUT_EN
      for (int c = 0; c < 8; c++) begin
`else
      for (int c = 0; c < 60; c++) begin
`endif
         if (rsp_valid) seen++;
         step();
      end
      chk("hang_no_rsp", seen, 0);
      chk("hang_ready_low", req_ready, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (rsp_valid) seen++;
      end
      chk("post_rst_no_rsp", seen, 0);
      chk("post_rst_ready", req_ready, 1);
      in_ctrl_data = rsp_word(32'h70000020, 64'h77); in_ctrl_data_wr = 1'b1;
      step();
      in_ctrl_data_wr = 1'b0;
      step();
      chk("post_rst_drop", drop_cnt, 1);
      chk("post_rst_no_rsp2", rsp_valid, 0);

      tv = vecs[0];
      tv.exp_drop = 16'd1;
      run_vec("recover", tv);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
